// File: rtl/m_mdu_issue_if.sv
// Pipeline <-> MDU issue controller bundle: E/D-stage requests in, MDU request,
// stall and status out. The pipeline side is master, the controller is slave.
interface m_mdu_issue_if;
    logic [4:0]  i_E_mduOp;
    logic [31:0] i_E_srcA;
    logic [31:0] i_E_srcB;
    logic        i_D_useMdu;
    logic        i_mduBusy;
    logic        o_start;
    logic [4:0]  o_mduOp;
    logic [31:0] o_srcA;
    logic [31:0] o_srcB;
    logic        o_stall;
    logic        o_protoErr;
    logic [31:0] o_stallCnt;

    modport master (
        output i_E_mduOp, i_E_srcA, i_E_srcB, i_D_useMdu, i_mduBusy,
        input  o_start, o_mduOp, o_srcA, o_srcB, o_stall, o_protoErr, o_stallCnt
    );

    modport slave (
        input  i_E_mduOp, i_E_srcA, i_E_srcB, i_D_useMdu, i_mduBusy,
        output o_start, o_mduOp, o_srcA, o_srcB, o_stall, o_protoErr, o_stallCnt
    );
endinterface

// File: rtl/m_mdu_issue.sv
// E-stage MDU issue/hazard controller: starts mult/div, models their latency,
// stalls D on MDU collisions, cross-checks MDU busy and counts stall cycles.
module m_mdu_issue #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic          i_clk,
    input logic          i_reset,
    m_mdu_issue_if.slave bus
);

    localparam logic [4:0] MDU_MULT  = 5'd1;
    localparam logic [4:0] MDU_MULTU = 5'd2;
    localparam logic [4:0] MDU_DIV   = 5'd3;
    localparam logic [4:0] MDU_DIVU  = 5'd4;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        post_rst_q;
    logic        proto_err_q;
    logic [31:0] stall_cnt;

    logic is_mult, is_div, is_md;
    logic start, stall, proto_viol;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        is_mult = (bus.i_E_mduOp == MDU_MULT) || (bus.i_E_mduOp == MDU_MULTU);
        is_div  = (bus.i_E_mduOp == MDU_DIV)  || (bus.i_E_mduOp == MDU_DIVU);
        is_md   = is_mult || is_div;
        start   = !i_reset && (state_q == S_IDLE) && is_md;
        stall   = bus.i_D_useMdu && (start || (state_q == S_CALC));
        // MDU busy must mirror CALC exactly; right after reset the MDU may
        // still be winding down, so the idle-side check is skipped once.
        proto_viol = ((state_q == S_CALC) && !bus.i_mduBusy)
                  || ((state_q == S_IDLE) && !post_rst_q && bus.i_mduBusy)
                  || ((state_q == S_CALC) && is_md);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            S_CALC: begin
                // An illegal issue in CALC is only flagged; the countdown of
                // the operation already in flight continues untouched.
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            post_rst_q  <= 1'b1;
            proto_err_q <= 1'b0;
            stall_cnt   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            post_rst_q <= 1'b0;
            if (proto_viol) begin
                proto_err_q <= 1'b1;
            end
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    assign bus.o_start    = start;
    assign bus.o_mduOp    = bus.i_E_mduOp;
    assign bus.o_srcA     = bus.i_E_srcA;
    assign bus.o_srcB     = bus.i_E_srcB;
    assign bus.o_stall    = stall;
    assign bus.o_protoErr = proto_err_q;
    assign bus.o_stallCnt = stall_cnt;

endmodule

// File: tb/tb_m_mdu_issue.sv
// Self-checking bench for m_mdu_issue: an MDU busy model, a start-request
// scoreboard and one task per scenario.
module tb_m_mdu_issue;

    localparam logic [4:0] MDU_NONE  = 5'd0;
    localparam logic [4:0] MDU_MULT  = 5'd1;
    localparam logic [4:0] MDU_MULTU = 5'd2;
    localparam logic [4:0] MDU_DIV   = 5'd3;
    localparam logic [4:0] MDU_DIVU  = 5'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    m_mdu_issue_if bus();

    m_mdu_issue #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // MDU model: busy for the operation's latency after the start edge.
    int   busy_cnt;
    logic busy_kill;
    logic busy_hold;
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (bus.o_start)
            busy_cnt <= ((bus.o_mduOp == MDU_DIV) || (bus.o_mduOp == MDU_DIVU)) ? 10 : 5;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.i_mduBusy = ((busy_cnt > 0) && !busy_kill) || busy_hold;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;
    req_t exp_q[$];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_scnt = 32'd0;

    // Scoreboard: every start request must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.o_start) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_start got op=%0d exp=no start", bus.o_mduOp);
            end else begin
                req_t e;
                e = exp_q.pop_front();
                if ({bus.o_mduOp, bus.o_srcA, bus.o_srcB} !== {e.op, e.a, e.b}) begin
                    errors++;
                    $display("FAIL sb_request got op=%0d a=%0d b=%0d exp op=%0d a=%0d b=%0d",
                             bus.o_mduOp, bus.o_srcA, bus.o_srcB, e.op, e.a, e.b);
                end
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_mdu);
        bus.i_E_mduOp  = op;
        bus.i_E_srcA   = a;
        bus.i_E_srcB   = b;
        bus.i_D_useMdu = use_mdu;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(MDU_MULT, 32'h1234, 32'h5678, 1'b1);
        #2;
        checks++;
        if ({bus.o_start, bus.o_stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_start_stall got=%b exp=00", {bus.o_start, bus.o_stall});
        end
        checks++;
        if ({bus.o_protoErr, bus.o_stallCnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state got err=%0b cnt=%0d exp err=0 cnt=0", bus.o_protoErr, bus.o_stallCnt);
        end
        checks++;
        if ({bus.o_mduOp, bus.o_srcA, bus.o_srcB} !== {MDU_MULT, 32'h1234, 32'h5678}) begin
            errors++;
            $display("FAIL reset_passthrough got op=%0d a=%h b=%h exp op=1 a=1234 b=5678",
                     bus.o_mduOp, bus.o_srcA, bus.o_srcB);
        end
        drive(MDU_NONE, 0, 0, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_mult;
        logic [9:0] svec;
        int n_start = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                drive(MDU_MULT, 32'd3, 32'd5, 1'b1);
                exp_q.push_back('{op: MDU_MULT, a: 32'd3, b: 32'd5});
            end else drive(MDU_NONE, 0, 0, 1'b1);
            #1;
            svec[i] = bus.o_stall;
            n_start += int'(bus.o_start);
            cyc();
        end
        exp_scnt = exp_scnt + 32'd6;
        checks++;
        if (svec !== 10'h03F) begin
            errors++;
            $display("FAIL mult_stall_window got=%b exp=%b", svec, 10'h03F);
        end
        checks++;
        if (n_start != 1) begin
            errors++;
            $display("FAIL mult_start_count got=%0d exp=1", n_start);
        end
        checks++;
        if (bus.o_stallCnt !== exp_scnt) begin
            errors++;
            $display("FAIL mult_stallcnt got=%0d exp=%0d", bus.o_stallCnt, exp_scnt);
        end
        checks++;
        if (bus.o_protoErr !== 1'b0) begin
            errors++;
            $display("FAIL mult_protoerr got=%0b exp=0", bus.o_protoErr);
        end
    endtask

    task automatic test_no_stall;
        logic any_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                drive(MDU_MULT, 32'd7, 32'd9, 1'b0);
                exp_q.push_back('{op: MDU_MULT, a: 32'd7, b: 32'd9});
            end else drive(MDU_NONE, 0, 0, 1'b0);
            #1;
            any_stall |= bus.o_stall;
            cyc();
        end
        checks++;
        if (any_stall !== 1'b0) begin
            errors++;
            $display("FAIL nostall_stall got=%0b exp=0", any_stall);
        end
        checks++;
        if (bus.o_stallCnt !== exp_scnt) begin
            errors++;
            $display("FAIL nostall_stallcnt got=%0d exp=%0d", bus.o_stallCnt, exp_scnt);
        end
    endtask

    task automatic test_div;
        logic [13:0] svec;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin
                drive(MDU_DIVU, 32'd100, 32'd7, 1'b1);
                exp_q.push_back('{op: MDU_DIVU, a: 32'd100, b: 32'd7});
            end else drive(MDU_NONE, 0, 0, 1'b1);
            #1;
            svec[i] = bus.o_stall;
            cyc();
        end
        exp_scnt = exp_scnt + 32'd11;
        checks++;
        if (svec !== 14'h07FF) begin
            errors++;
            $display("FAIL div_stall_window got=%b exp=%b", svec, 14'h07FF);
        end
        checks++;
        if (bus.o_stallCnt !== exp_scnt || bus.o_protoErr !== 1'b0) begin
            errors++;
            $display("FAIL div_status got cnt=%0d err=%0b exp cnt=%0d err=0",
                     bus.o_stallCnt, bus.o_protoErr, exp_scnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] svec;
        logic [12:0] stvec;
        for (int i = 0; i < 13; i++) begin
            if (i == 0) begin
                drive(MDU_MULT, 32'd11, 32'd13, 1'b1);
                exp_q.push_back('{op: MDU_MULT, a: 32'd11, b: 32'd13});
            end else if (i < 6) drive(MDU_NONE, 0, 0, 1'b1);
            else if (i == 6) begin
                drive(MDU_MULTU, 32'd17, 32'd19, 1'b0);
                exp_q.push_back('{op: MDU_MULTU, a: 32'd17, b: 32'd19});
            end else drive(MDU_NONE, 0, 0, 1'b0);
            #1;
            svec[i]  = bus.o_stall;
            stvec[i] = bus.o_start;
            cyc();
        end
        exp_scnt = exp_scnt + 32'd6;
        checks++;
        if (stvec !== 13'h0041) begin
            errors++;
            $display("FAIL b2b_start_cycles got=%b exp=%b", stvec, 13'h0041);
        end
        checks++;
        if (svec !== 13'h003F) begin
            errors++;
            $display("FAIL b2b_stall_window got=%b exp=%b", svec, 13'h003F);
        end
        checks++;
        if (bus.o_stallCnt !== exp_scnt || bus.o_protoErr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_status got cnt=%0d err=%0b exp cnt=%0d err=0",
                     bus.o_stallCnt, bus.o_protoErr, exp_scnt);
        end
    endtask

    task automatic test_busy_mismatch;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                drive(MDU_MULT, 32'd2, 32'd4, 1'b0);
                exp_q.push_back('{op: MDU_MULT, a: 32'd2, b: 32'd4});
            end else drive(MDU_NONE, 0, 0, 1'b0);
            busy_kill = (i == 2);
            #1;
            if (i == 2) begin
                checks++;
                if (bus.o_protoErr !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_err_early got=%0b exp=0", bus.o_protoErr);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.o_protoErr !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_err_set got=%0b exp=1", bus.o_protoErr);
                end
            end
            cyc();
        end
        busy_kill = 1'b0;
        checks++;
        if (bus.o_protoErr !== 1'b1) begin
            errors++;
            $display("FAIL busy_err_sticky got=%0b exp=1", bus.o_protoErr);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] svec;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                drive(MDU_DIV, 32'd50, 32'd5, 1'b1);
                exp_q.push_back('{op: MDU_DIV, a: 32'd50, b: 32'd5});
            end else drive(MDU_NONE, 0, 0, 1'b1);
            #1;
            if (i < 3) cyc();
        end
        checks++;
        if (bus.o_stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stall_before got=%0b exp=1", bus.o_stall);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_stall, bus.o_start, bus.o_protoErr} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_async got stall/start/err=%b exp=000",
                     {bus.o_stall, bus.o_start, bus.o_protoErr});
        end
        cyc();
        rst = 1'b0;
        busy_hold = 1'b1;
        exp_scnt = 32'd0;
        checks++;
        if (bus.o_stallCnt !== exp_scnt) begin
            errors++;
            $display("FAIL rstmid_stallcnt got=%0d exp=0", bus.o_stallCnt);
        end
        drive(MDU_NONE, 0, 0, 1'b0);
        cyc();
        busy_hold = 1'b0;
        checks++;
        if (bus.o_protoErr !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy_mask got=%0b exp=0", bus.o_protoErr);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                drive(MDU_MULT, 32'd3, 32'd5, 1'b1);
                exp_q.push_back('{op: MDU_MULT, a: 32'd3, b: 32'd5});
            end else drive(MDU_NONE, 0, 0, 1'b1);
            #1;
            svec[i] = bus.o_stall;
            cyc();
        end
        exp_scnt = exp_scnt + 32'd6;
        checks++;
        if (svec !== 10'h03F || bus.o_stallCnt !== exp_scnt || bus.o_protoErr !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_restart got stall=%b cnt=%0d err=%0b exp stall=%b cnt=%0d err=0",
                     svec, bus.o_stallCnt, bus.o_protoErr, 10'h03F, exp_scnt);
        end
    endtask

    task automatic test_sat_illegal;
        logic [9:0] svec;
        drive(MDU_NONE, 0, 0, 1'b0);
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt;
        #1;
        checks++;
        if (bus.o_stallCnt !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sat_preload got=%h exp=fffffffe", bus.o_stallCnt);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                drive(MDU_MULT, 32'd6, 32'd7, 1'b1);
                exp_q.push_back('{op: MDU_MULT, a: 32'd6, b: 32'd7});
            end else if (i == 2) drive(MDU_DIV, 32'd8, 32'd9, 1'b1);
            else drive(MDU_NONE, 0, 0, 1'b1);
            #1;
            svec[i] = bus.o_stall;
            if (i == 1 || i == 3) begin
                checks++;
                if (bus.o_stallCnt !== 32'hFFFF_FFFF) begin
                    errors++;
                    $display("FAIL sat_value_c%0d got=%h exp=ffffffff", i, bus.o_stallCnt);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.o_start !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_start got=%0b exp=0", bus.o_start);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.o_protoErr !== 1'b1) begin
                    errors++;
                    $display("FAIL illegal_protoerr got=%0b exp=1", bus.o_protoErr);
                end
            end
            cyc();
        end
        checks++;
        if (svec !== 10'h03F || bus.o_stallCnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL illegal_timing got stall=%b cnt=%h exp stall=%b cnt=ffffffff",
                     svec, bus.o_stallCnt, 10'h03F);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        busy_kill = 1'b0;
        busy_hold = 1'b0;
        test_reset();
        test_single_mult();
        test_no_stall();
        test_div();
        test_back_to_back();
        test_busy_mismatch();
        test_reset_mid();
        test_sat_illegal();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
